// File: rtl/whack_judge.sv
// whack_judge: whack-a-mole trial referee.
// Takes one mole position at a time and opens a timed window. The trial ends
// with hit_o when that hole's key rises, and with miss_o when a different key
// rises or the window expires. A two-digit BCD score is kept.
// Optional feature macro: WHACK_PENALTY_EN (each miss lowers the score by one,
// stopping at 00).
module whack_judge #(
  parameter int unsigned WINDOW_CYCLES = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_i,
  input  logic       mole_valid_i,
  input  logic [2:0] mole_pos_i,
  output logic       mole_ready_o,
  output logic       hit_o,
  output logic       miss_o,
  output logic       busy_o,
  output logic [7:0] score_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    RESULT = 2'd2
  } state_e;

  // The timer counts down to zero, so loading WINDOW_CYCLES-1 gives exactly
  // WINDOW_CYCLES evaluation cycles.
  localparam logic [31:0] TIMER_LOAD = 32'(WINDOW_CYCLES - 32'd1);

  // BCD increment that stops at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99) begin
      r = s;
    end else if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD decrement that stops at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h00) begin
      r = s;
    end else if (s[3:0] == 4'd0) begin
      r = {s[7:4] - 4'd1, 4'd9};
    end else begin
      r = {s[7:4], s[3:0] - 4'd1};
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  pos_q, pos_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  rise;

  assign rise = key_i & ~key_q;

  // Next-state, timer, and result logic for the trial FSM.
  always_comb begin
    state_d = state_q;
    key_d   = key_i;
    timer_d = timer_q;
    pos_d   = pos_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        // Rises seen in the accept cycle are ignored on purpose.
        if (mole_valid_i) begin
          pos_d   = mole_pos_i;
          timer_d = TIMER_LOAD;
          state_d = WINDOW;
        end else begin
          state_d = IDLE;
        end
      end
      WINDOW: begin
        // Priority: correct rise, then wrong rise, then timeout.
        if (rise[pos_q]) begin
          hit_d   = 1'b1;
          score_d = bcd_inc(score_q);
          state_d = RESULT;
        end else if (rise != 8'h00 || timer_q == 32'd0) begin
          miss_d  = 1'b1;
`ifdef WHACK_PENALTY_EN
          score_d = bcd_dec(score_q);
`else
          score_d = score_q;
`endif
          state_d = RESULT;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      RESULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 8'h00;
      timer_q <= 32'd0;
      pos_q   <= 3'd0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= 8'h00;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
    end
  end

  assign mole_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q == WINDOW);
  assign hit_o        = hit_q;
  assign miss_o       = miss_q;
  assign score_o      = score_q;

endmodule

// File: doc/whack_judge.md
WHACK_JUDGE -- requirements
Module: whack_judge

Interface
REQ-001 Parameter WINDOW_CYCLES, default 50_000_000: length of the whack window in clk cycles; legal range 2..2^32-1.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 key_i  input  8  debounced key levels, one per hole; high = pressed.
REQ-005 mole_valid_i  input  1  new mole offered.
REQ-006 mole_pos_i  input  3  hole index of the offered mole.
REQ-007 mole_ready_o  output  1  block can accept a mole.
REQ-008 hit_o  output  1  one-cycle pulse: correct hole struck in window.
REQ-009 miss_o  output  1  one-cycle pulse: wrong hole struck, or window expired.
REQ-010 busy_o  output  1  high while a window is open.
REQ-011 score_o  output  8  two-digit BCD score; [7:4] tens, [3:0] units.

Function
REQ-012 The block SHALL register key_i every cycle into key_q; rise[i] = key_i[i] & ~key_q[i].
REQ-013 The FSM SHALL have states IDLE, WINDOW and RESULT.
REQ-014 mole_ready_o SHALL equal (state == IDLE), and busy_o SHALL equal (state == WINDOW).
REQ-015 In IDLE, mole_valid_i & mole_ready_o at a clock edge SHALL latch mole_pos_i, load the timer with WINDOW_CYCLES-1, and enter WINDOW.
REQ-016 Rises SHALL be evaluated only in WINDOW; rises in IDLE or RESULT, including in the accept cycle, SHALL be ignored.
REQ-017 In WINDOW, rise[pos] SHALL at that edge set hit_o, increment score, and enter RESULT.
REQ-018 In WINDOW with no rise[pos] but any other rise bit set, the block SHALL set miss_o and enter RESULT.
REQ-019 In WINDOW with no rise and timer == 0, the block SHALL set miss_o and enter RESULT; otherwise the timer SHALL decrement by 1.
REQ-020 Window length SHALL be exactly WINDOW_CYCLES cycles of rise evaluation, the first being the cycle after acceptance.
REQ-021 Priority SHALL be: correct rise > wrong rise > timeout; a correct rise on the timer == 0 cycle counts as a hit.
REQ-022 hit_o and miss_o SHALL be registered, high for exactly one cycle, mutually exclusive, and aligned with the RESULT cycle.
REQ-023 RESULT SHALL last exactly one cycle and then return to IDLE; the minimum accept-to-accept spacing is 3 cycles.
REQ-024 Score increment SHALL be BCD-correct (09->10, 19->20) and SHALL saturate at 99.
REQ-025 score_o SHALL update on the same edge as the hit_o/miss_o assertion.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL enter IDLE with key_q = 0, timer = 0, hit_o = 0, miss_o = 0, score_o = 8'h00 and latched position = 0.
REQ-027 The reset outputs SHALL be mole_ready_o = 1 and busy_o = 0, and rst SHALL override every other input in the same cycle.
REQ-028 A reset asserted mid-WINDOW or mid-RESULT SHALL abort the trial with no hit_o/miss_o pulse.
REQ-029 The first WINDOW after reset SHALL NOT see a spurious rise from a key held through reset, because key_q has resynced during the IDLE cycles.

Configuration
REQ-030 Macro WHACK_PENALTY_EN: when defined, each miss_o SHALL decrement score in BCD (10->09), saturating at 00.
REQ-031 Without WHACK_PENALTY_EN, miss_o SHALL leave the score unchanged; all other behaviour SHALL be identical.

Verification (WINDOW_CYCLES = 10)
REQ-032 Hit: accept pos=3, raise key_i[3] at window cycle 4 -> hit_o pulses once on that edge, score 00->01, then ready returns after 1 cycle.
REQ-033 Timeout: accept pos=5, no keys -> miss_o pulses exactly 10 cycles after acceptance; score 00 (penalty build: stays 00).
REQ-034 Wrong key plus simultaneous correct key: accept pos=2, raise key_i[2] and key_i[6] on the same cycle -> hit_o only; wrong key alone -> miss_o, and with penalty score 05->04.
REQ-035 Held key: key_i[1] held high before acceptance of pos=1 -> no hit for the whole window, miss_o at timeout.
REQ-036 BCD/saturation: 9 hits -> 09, 10th hit -> 10; at 99 a further hit -> 99.
REQ-037 Mid-window reset: assert rst at window cycle 5 -> no pulse, score 00, mole_ready_o = 1 on the next cycle.
